// File: rtl/bcd_conv_arbiter.sv
// Shared shift-add-3 binary-to-BCD converter serving two requesters round-robin.
// One operand bit is consumed per clock; the result is held until the consumer accepts it.
module bcd_conv_arbiter #(
    parameter int unsigned BIN_W  = 7,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    input  logic [BIN_W-1:0]      req_bin0,
    input  logic [BIN_W-1:0]      req_bin1,
    output logic [1:0]            req_ready,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [4*DIGITS-1:0]   rsp_bcd,
    output logic                  rsp_ovf,
    input  logic                  rsp_ready,
    output logic                  busy
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              id_q, id_d;
    logic [BIN_W-1:0]  shift_q, shift_d;
    logic [BcdW-1:0]   acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [BcdW-1:0]   rsp_bcd_q, rsp_bcd_d;
    logic              rsp_id_q, rsp_id_d;
    logic              rsp_ovf_q, rsp_ovf_d;

    logic [BcdW-1:0]   acc_adj;
    logic [BcdW-1:0]   acc_shift;
    logic              carry_out;
    logic              sel;

    // Add-3 correction on every digit, then shift in the next operand bit.
    always_comb begin
        acc_adj = acc_q;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (acc_q[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
            end
        end
        acc_shift = {acc_adj[BcdW-2:0], shift_q[BIN_W-1]};
        carry_out = acc_adj[BcdW-1];
    end

    // Grant is combinational and only offered in IDLE; a tie goes to the requester != last.
    always_comb begin
        req_ready = 2'b00;
        if (state_q == StIdle && !rst) begin
            case (req_valid)
                2'b01:   req_ready = 2'b01;
                2'b10:   req_ready = 2'b10;
                2'b11:   req_ready = last_q ? 2'b01 : 2'b10;
                default: req_ready = 2'b00;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        id_d      = id_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        rsp_bcd_d = rsp_bcd_q;
        rsp_id_d  = rsp_id_q;
        rsp_ovf_d = rsp_ovf_q;
        sel       = req_ready[1];
        unique case (state_q)
            StIdle: begin
                if (|(req_valid & req_ready)) begin
                    shift_d = sel ? req_bin1 : req_bin0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    id_d    = sel;
                    last_d  = sel;
                    cnt_d   = '0;
                    state_d = StConv;
                end
            end
            StConv: begin
                acc_d   = acc_shift;
                shift_d = shift_q << 1;
                ovf_d   = ovf_q | carry_out;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CntW'(BIN_W - 1)) begin
                    state_d   = StDone;
                    rsp_bcd_d = acc_shift;
                    rsp_id_d  = id_q;
                    rsp_ovf_d = ovf_q | carry_out;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            id_q      <= 1'b0;
            shift_q   <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            rsp_bcd_q <= '0;
            rsp_id_q  <= 1'b0;
            rsp_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            id_q      <= id_d;
            shift_q   <= shift_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            rsp_bcd_q <= rsp_bcd_d;
            rsp_id_q  <= rsp_id_d;
            rsp_ovf_q <= rsp_ovf_d;
        end
    end

    assign rsp_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign rsp_bcd   = rsp_bcd_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter: vector table plus arbitration, hold and reset sequences.
module tb_bcd_conv_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [6:0]  req_bin0, req_bin1;
    logic [1:0]  req_ready;
    logic        rsp_valid, rsp_id, rsp_ovf, rsp_ready, busy;
    logic [11:0] rsp_bcd;

    logic [1:0]  v2;
    logic [6:0]  b2_0, b2_1;
    logic [1:0]  rr2;
    logic        rv2, id2, ovf2, rdy2, busy2;
    logic [7:0]  bcd2;

    int checks = 0;
    int failures = 0;
    int rr_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_conv_arbiter #(.BIN_W(7), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_bin0(req_bin0), .req_bin1(req_bin1),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_bcd(rsp_bcd),
        .rsp_ovf(rsp_ovf), .rsp_ready(rsp_ready), .busy(busy)
    );

    bcd_conv_arbiter #(.BIN_W(7), .DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_bin0(b2_0), .req_bin1(b2_1),
        .req_ready(rr2), .rsp_valid(rv2), .rsp_id(id2), .rsp_bcd(bcd2),
        .rsp_ovf(ovf2), .rsp_ready(rdy2), .busy(busy2)
    );

    typedef struct {
        logic [1:0]  valid;
        logic [6:0]  bin0;
        logic [6:0]  bin1;
        logic        exp_id;
        logic [11:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Counts negedges until rsp_valid; flags any grant seen while busy.
    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 40) begin
            if (busy && req_ready != 2'b00) rr_bad++;
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) check("rsp_timeout", 0, 1);
    endtask

    vec_t vecs[7];
    int   n, t_prev, hold_bad;
    logic [6:0] ops2[4];
    logic [7:0] exp2[4];
    logic       eovf2[4];

    initial begin
        vecs[0] = '{2'b01, 7'd127, 7'd0,   1'b0, 12'h127, 1'b0};
        vecs[1] = '{2'b01, 7'd0,   7'd0,   1'b0, 12'h000, 1'b0};
        vecs[2] = '{2'b01, 7'd99,  7'd0,   1'b0, 12'h099, 1'b0};
        vecs[3] = '{2'b01, 7'd5,   7'd0,   1'b0, 12'h005, 1'b0};
        vecs[4] = '{2'b10, 7'd0,   7'd64,  1'b1, 12'h064, 1'b0};
        vecs[5] = '{2'b10, 7'd0,   7'd100, 1'b1, 12'h100, 1'b0};
        vecs[6] = '{2'b10, 7'd3,   7'd10,  1'b1, 12'h010, 1'b0};
        ops2  = '{7'd100, 7'd99, 7'd127, 7'd0};
        exp2  = '{8'h00, 8'h99, 8'h27, 8'h00};
        eovf2 = '{1'b1, 1'b0, 1'b1, 1'b0};

        // Reset with both requesters valid.
        rst = 1'b1; req_valid = 2'b11; req_bin0 = 7'd42; req_bin1 = 7'd7; rsp_ready = 1'b1;
        v2 = 2'b00; b2_0 = '0; b2_1 = '0; rdy2 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_bcd", rsp_bcd, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_ovf", rsp_ovf, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        #1 check("first_grant", req_ready, 2'b01);

        // Both permanently valid: strict alternation at the minimum period.
        for (int k = 0; k < 4; k++) begin
            wait_rsp(n);
            check("alt_id", rsp_id, k % 2);
            check("alt_bcd", rsp_bcd, (k % 2) ? 12'h007 : 12'h042);
            if (k > 0) check("alt_period", cyc - t_prev, 9);
            t_prev = cyc;
            if (k == 3) req_valid = 2'b00;
            @(negedge clk);
        end
        check("no_grant_while_busy", rr_bad, 0);

        // Consumer stalls; operand change during hold must be ignored.
        req_valid = 2'b01; req_bin0 = 7'd99; rsp_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        wait_rsp(n);
        check("hold_bcd", rsp_bcd, 12'h099);
        req_bin0 = 7'd5;
        hold_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!rsp_valid || rsp_bcd != 12'h099 || rsp_id != 1'b0 || req_ready != 2'b00)
                hold_bad++;
        end
        check("hold_stable", hold_bad, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("release_valid", rsp_valid, 0);
        check("release_busy", busy, 0);
        check("release_grant", req_ready, 2'b01);
        check("persist_bcd", rsp_bcd, 12'h099);
        @(negedge clk);
        check("regrant_busy", busy, 1);
        req_valid = 2'b00;
        wait_rsp(n);
        check("regrant_lat", n, 7);
        check("regrant_bcd", rsp_bcd, 12'h005);
        @(negedge clk);

        // Single-requester vector table.
        foreach (vecs[i]) begin
            req_valid = vecs[i].valid; req_bin0 = vecs[i].bin0; req_bin1 = vecs[i].bin1;
            #1 check("vec_grant", req_ready, vecs[i].valid);
            @(posedge clk); @(negedge clk);
            req_valid = 2'b00; req_bin0 = 7'd111; req_bin1 = 7'd111;
            wait_rsp(n);
            check("vec_latency", n, 7);
            check("vec_bcd", rsp_bcd, vecs[i].exp_bcd);
            check("vec_id", rsp_id, vecs[i].exp_id);
            check("vec_ovf", rsp_ovf, vecs[i].exp_ovf);
            @(negedge clk);
            check("vec_pulse", rsp_valid, 0);
        end

        // Reset at CONV iteration 3 discards the job and restores priority to requester 0.
        req_valid = 2'b01; req_bin0 = 7'd127;
        @(posedge clk); @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", rsp_valid, 0);
        check("abort_bcd", rsp_bcd, 0);
        req_valid = 2'b11;
        #1 check("abort_last", req_ready, 2'b01);
        req_valid = 2'b10; req_bin1 = 7'd64;
        #1 check("abort_grant1", req_ready, 2'b10);
        @(posedge clk); @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(n);
        check("abort_lat", n, 7);
        check("abort_id", rsp_id, 1);
        check("abort_res", rsp_bcd, 12'h064);
        @(negedge clk);

        // Two-digit instance: truncation and overflow flag.
        foreach (ops2[i]) begin
            v2 = 2'b01; b2_0 = ops2[i];
            @(posedge clk); @(negedge clk);
            v2 = 2'b00;
            n = 0;
            while (!rv2 && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("d2_lat", n, 7);
            check("d2_bcd", bcd2, exp2[i]);
            check("d2_ovf", ovf2, eovf2[i]);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
